// File: rtl/cnu_ib_ram_loader.sv
`default_nettype none
// ============================================================================
//  Module   : cnu_ib_ram_loader
//  Function : Unpacks a valid/ready stream of packed LUT words into one
//             CNU information-bottleneck LUT RAM write per cycle.
//  Revision : 1.0  initial release
// ============================================================================
module cnu_ib_ram_loader #(
    parameter int QUAN_SIZE = 4,
    parameter int IB_ADDR   = 8,
    parameter int RAM_DEPTH = 256,
    parameter int PACK      = 4
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic                        load_start,
    input  logic                        abort,
    input  logic [QUAN_SIZE*PACK-1:0]   in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        ib_ram_we,
    output logic [IB_ADDR-1:0]          ib_ram_waddr,
    output logic [QUAN_SIZE-1:0]        ib_ram_wdata,
    output logic                        busy,
    output logic                        load_done
);

    localparam int              BUF_W      = QUAN_SIZE * PACK;
    localparam logic [1:0]      S_IDLE     = 2'd0;
    localparam logic [1:0]      S_LOAD     = 2'd1;
    localparam logic [1:0]      S_DONE     = 2'd2;
    localparam logic [2:0]      PACK_CNT   = 3'(PACK);
    localparam logic [6:0]      WORD_LIMIT = 7'(RAM_DEPTH / PACK);
    localparam logic [IB_ADDR-1:0] LAST_ADDR = IB_ADDR'(RAM_DEPTH - 1);

    logic [1:0]             state_q, state_d;
    logic [BUF_W-1:0]       buf_q, buf_d;
    logic [2:0]             slot_cnt_q, slot_cnt_d;
    logic [IB_ADDR-1:0]     addr_cnt_q, addr_cnt_d;
    logic [6:0]             word_cnt_q, word_cnt_d;
    logic                   we_q, we_d;
    logic [IB_ADDR-1:0]     waddr_q, waddr_d;
    logic [QUAN_SIZE-1:0]   wdata_q, wdata_d;
    logic                   done_q, done_d;
    logic                   w_accept;
    logic                   w_emit;

    assign in_ready = (state_q == S_LOAD) && (slot_cnt_q <= 3'd1) &&
                      (word_cnt_q < WORD_LIMIT);
    assign w_accept = in_valid && in_ready;
    assign w_emit   = (slot_cnt_q != 3'd0);

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        slot_cnt_d = slot_cnt_q;
        addr_cnt_d = addr_cnt_q;
        word_cnt_d = word_cnt_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!abort && load_start) begin
                    state_d    = S_LOAD;
                    buf_d      = '0;
                    slot_cnt_d = 3'd0;
                    addr_cnt_d = '0;
                    word_cnt_d = 7'd0;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d    = S_IDLE;
                    buf_d      = '0;
                    slot_cnt_d = 3'd0;
                    addr_cnt_d = '0;
                    word_cnt_d = 7'd0;
                end else begin
                    if (w_emit) begin
                        we_d       = 1'b1;
                        waddr_d    = addr_cnt_q;
                        wdata_d    = buf_q[QUAN_SIZE-1:0];
                        buf_d      = buf_q >> QUAN_SIZE;
                        addr_cnt_d = addr_cnt_q + 1'b1;
                        slot_cnt_d = slot_cnt_q - 3'd1;
                        if (addr_cnt_q == LAST_ADDR) begin
                            state_d = S_DONE;
                        end
                    end
                    // A new word may overwrite the buffer on the same edge its last entry leaves.
                    if (w_accept) begin
                        buf_d      = in_data;
                        slot_cnt_d = PACK_CNT;
                        word_cnt_d = word_cnt_q + 7'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (abort) begin
                    buf_d      = '0;
                    slot_cnt_d = 3'd0;
                    addr_cnt_d = '0;
                    word_cnt_d = 7'd0;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            buf_q      <= '0;
            slot_cnt_q <= 3'd0;
            addr_cnt_q <= '0;
            word_cnt_q <= 7'd0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            slot_cnt_q <= slot_cnt_d;
            addr_cnt_q <= addr_cnt_d;
            word_cnt_q <= word_cnt_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
        end
    end

    assign ib_ram_we    = we_q;
    assign ib_ram_waddr = waddr_q;
    assign ib_ram_wdata = wdata_q;
    assign busy         = (state_q == S_LOAD);
    assign load_done    = done_q;

endmodule
`default_nettype wire

// File: doc/cnu_ib_ram_loader.md
Name: cnu_ib_ram_loader

Overview:
Write-side controller for the reconfigurable CNU information-bottleneck LUT RAM (256 entries x 4 bits). It accepts a valid/ready stream of packed 16-bit words, each holding four 4-bit LUT entries. It unpacks each word into one RAM write per cycle at consecutive addresses 0..255. When the table is complete it signals load_done, which lets the CNU datapath start lookups.

Parameters:
QUAN_SIZE, 4, bit width of one LUT entry.
IB_ADDR, 8, LUT RAM address width.
RAM_DEPTH, 256, number of LUT entries to load (2**IB_ADDR).
PACK, 4, entries per input word; input word width = QUAN_SIZE*PACK = 16.

Ports:
sys_clk  input  1  system clock; all state updates on posedge.
sys_rst  input  1  asynchronous active-high reset.
load_start  input  1  single-cycle pulse; begins a table load when idle.
abort  input  1  synchronous; cancels a load in progress.
in_data  input  16  packed entries; entry j occupies bits [4j+3:4j], with entry 0 written first.
in_valid  input  1  in_data valid.
in_ready  output  1  loader can accept in_data this cycle.
ib_ram_we  output  1  RAM write enable (registered).
ib_ram_waddr  output  8  RAM write address (registered).
ib_ram_wdata  output  4  RAM write data (registered).
busy  output  1  high while a load is in progress (LOAD state).
load_done  output  1  one-cycle pulse after the final write.

Behaviour:
- Clock and reset:
  - One clock, sys_clk.
  - sys_rst is asynchronous and active-high.
  - On reset, all outputs and state go to 0 immediately: state=IDLE, slot_cnt=0, addr_cnt=0, word_cnt=0.
- State machine has three states: IDLE, LOAD, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - load_start=1 -> LOAD; clear addr_cnt, word_cnt and slot_cnt.
- LOAD:
  - busy=1.
  - in_ready = (slot_cnt<=1) && (word_cnt<RAM_DEPTH/PACK); this is combinational from registers.
  - Accept on in_valid && in_ready: the shift buffer loads in_data, slot_cnt becomes PACK, word_cnt increments.
  - While slot_cnt>0, each edge emits one entry:
    - ib_ram_we<=1, ib_ram_waddr<=addr_cnt, ib_ram_wdata<=buf[3:0].
    - buf shifts right by 4; addr_cnt increments; slot_cnt decrements.
  - An accept and the last-slot emission may occur on the same edge. The new word then replaces the buffer (slot_cnt=PACK) and the last entry is still written. This gives full throughput: ib_ram_we is continuous under continuous in_valid.
  - Latency: for a word accepted at edge N, ib_ram_we is high after edges N+1..N+4 with entries 0..3.
  - No emission on an edge -> ib_ram_we<=0; waddr and wdata hold their last value.
  - When the entry for address 255 is emitted -> DONE. addr_cnt wraps to 0 and is not used further.
- DONE: load_done=1 for exactly one cycle, ib_ram_we=0, then -> IDLE.
- Input handshake rules:
  - Upstream holds in_data stable while in_valid && !in_ready.
  - The 65th and later words are never accepted (in_ready=0).
- Start and abort:
  - load_start in LOAD or DONE is ignored.
  - abort (priority over all else) in LOAD or DONE:
    - Next state IDLE; ib_ram_we<=0; load_done stays 0; buffer and counters are cleared.
    - Words already written remain in the RAM.
  - abort in IDLE has no effect.
  - load_start and abort asserted together in IDLE: abort wins, so the loader stays IDLE.
- Arithmetic: addr_cnt is IB_ADDR bits wide, word_cnt is 7 bits, slot_cnt is 3 bits; all increments are unsigned.
- Read side: the RAM reads on negedge. Consumers must not issue lookups until load_done has been seen.

Test Plan:
1. Full load, in_valid held high, word k = {4k+3,4k+2,4k+1,4k} with each nibble mod 16 -> ib_ram_we high for 256 consecutive cycles; waddr 0..255; wdata = waddr[3:0]; load_done pulses once, the cycle after waddr=255; in_ready=0 after the 64th accept.
2. in_valid asserted every third cycle with the same data -> gaps in ib_ram_we; waddr sequence still contiguous 0..255; no duplicated or skipped entries; exactly 64 accepts.
3. abort asserted in the cycle where waddr=100 -> ib_ram_we=0 and busy=0 from the next cycle; no load_done. A following load_start restarts at waddr=0.
4. load_start re-pulsed at waddr=50 -> ignored; sequence continues 51,52,... and load_done arrives at the normal time.
5. sys_rst asserted mid-cycle at waddr=200 -> ib_ram_we, busy, in_ready and load_done are 0 before the next sys_clk edge; after release the loader stays IDLE until load_start.
6. Load a table with wdata = 15 - addr[3:0], then drive reads through the LUT RAM at addresses 0, 17 and 255 after load_done -> outputs 15, 14 and 0.
